hamming_decoder_pipe: RTL and testbench
=======================================

// Module: hamming_decoder_pipe
// PURPOSE
//  Receive-side counterpart of the team's Hamming(7,4) encoder.
//  - Accepts 7-bit codewords over a valid/ready stream and computes the 3-bit syndrome.
//  - Corrects any single-bit error and delivers the 4-bit message downstream.
//  - Two register stages; full throughput (1 word/cycle) when downstream is ready.
//  - Keeps a saturating count of corrected words for link-quality monitoring.
// PARAMETERS
//  CNT_W   16   width of corrected-word counter corr_count
// PORTS
//  clk         in   1      single clock; all state updates on rising edge
//  rst         in   1      synchronous, active-high reset
//  in_valid    in   1      code_in valid
//  in_ready    out  1      block can accept code_in this cycle
//  code_in     in   [1:7]  codeword {p1,p2,d1,p3,d2,d3,d4}; index = Hamming position
//  out_valid   out  1      msg_out/err_pos/corrected valid
//  out_ready   in   1      downstream accepts output this cycle
//  msg_out     out  [1:4]  corrected message {d1,d2,d3,d4}
//  err_pos     out  3      syndrome {s3,s2,s1}; 0 = no error, else flipped bit position 1..7
//  corrected   out  1      err_pos != 0
//  clr_cnt     in   1      synchronous clear of corr_count
//  corr_count  out  CNT_W  saturating count of corrected words delivered
// BEHAVIOUR
//  - Reset: out_valid=0, msg_out=0, err_pos=0, corrected=0, corr_count=0, internal valids=0.
//    in_ready=1 in the first cycle after reset.
//  - Syndrome:
//    s1 = c1^c3^c5^c7; s2 = c2^c3^c6^c7; s3 = c4^c5^c6^c7.
//  - Stage 1 (on input handshake): register code_in and syndrome; set s1_valid.
//  - Stage 2: flip bit code[err_pos] when err_pos != 0, then extract {c3,c5,c6,c7}
//    into msg_out; register msg_out/err_pos/corrected; set out_valid.
//  - Handshake / advance rules:
//    adv2 = !out_valid | out_ready; in_ready = !s1_valid | adv2 (combinational, no bubble).
//    Stage 1 moves into stage 2 when s1_valid & adv2.
//    s1_valid clears if stage 1 drains with no new input.
//    out_valid clears on output handshake with no stage-1 data behind it.
//  - Latency: input handshake in cycle N -> out_valid in cycle N+2 when out_ready is held 1.
//  - Stall: out_valid & !out_ready holds msg_out/err_pos/corrected stable.
//    Stage 1 holds its word. in_ready drops only when both stages are full.
//  - Parity-bit errors (err_pos = 1, 2 or 4): msg_out unchanged from the received data bits;
//    corrected=1.
//  - Distance-3 code: double errors are miscorrected silently; no double-error flag exists.
//  - corr_count: +1 on each output handshake (out_valid & out_ready) with corrected=1.
//    Saturates at 2^CNT_W-1.
//    clr_cnt has priority over an increment in the same cycle (result 0).
//  - rst mid-stream: all in-flight words are discarded; no output handshake for them.
//  - X on code_in while in_valid=0 must not propagate to outputs or the counter.
// TESTING
//  1. Clean word: code_in=7'b0110011, out_ready=1
//     -> 2 cycles later msg_out=4'b1011, err_pos=0, corrected=0, corr_count=0.
//  2. Data error: code_in=7'b0110111 (bit5 flipped)
//     -> msg_out=4'b1011, err_pos=3'd5, corrected=1, corr_count=1.
//  3. Parity error: code_in=7'b1000000
//     -> msg_out=4'b0000, err_pos=3'd1, corrected=1.
//     Sweep all 16 messages x 8 error cases (none, bits 1..7) -> message always recovered.
//  4. Backpressure: stream 4 words with out_ready=0 for 5 cycles
//     -> in_ready=0 after 2 accepted; outputs stable; order preserved on release.
//     No loss or duplication.
//  5. Counter:
//     - CNT_W=2: 5 corrected words -> corr_count=3 (saturated).
//     - clr_cnt coincident with a corrected handshake -> corr_count=0.
//  6. Reset mid-stream: rst with both stages full
//     -> next cycle out_valid=0, in_ready=1, corr_count=0; following word decodes normally.

Source files
------------

// File: rtl/hamming_decoder_pipe_if.sv
// Stream bundle for the Hamming(7,4) decoder: codeword in, corrected message out.
interface hamming_decoder_pipe_if;
    logic       in_valid;
    logic       in_ready;
    logic [1:7] code_in;
    logic       out_valid;
    logic       out_ready;
    logic [1:4] msg_out;
    logic [2:0] err_pos;
    logic       corrected;

    modport slave (
        input  in_valid, code_in, out_ready,
        output in_ready, out_valid, msg_out, err_pos, corrected
    );

    modport master (
        output in_valid, code_in, out_ready,
        input  in_ready, out_valid, msg_out, err_pos, corrected
    );
endinterface

// File: rtl/hamming_decoder_pipe.sv
// Two-stage Hamming(7,4) decoder: syndrome in stage 1, single-bit correction in stage 2,
// plus a saturating count of corrected words handed downstream.
module hamming_decoder_pipe #(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    hamming_decoder_pipe_if.slave bus,
    input  logic                 clr_cnt,
    output logic [CNT_W-1:0]     corr_count
);

    logic       s1_valid;
    logic [1:7] s1_code;
    logic [2:0] s1_syn;
    logic [2:0] syn;
    logic [1:7] fixed;
    logic [1:4] fix_msg;
    logic       adv2;
    logic       take;
    logic       out_hs;

    assign adv2         = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = !s1_valid || adv2;
    assign take         = bus.in_valid && bus.in_ready;
    assign out_hs       = bus.out_valid && bus.out_ready;

    // syndrome is {s3,s2,s1}, i.e. directly the position of the flipped bit
    always_comb begin
        syn[0] = bus.code_in[1] ^ bus.code_in[3] ^ bus.code_in[5] ^ bus.code_in[7];
        syn[1] = bus.code_in[2] ^ bus.code_in[3] ^ bus.code_in[6] ^ bus.code_in[7];
        syn[2] = bus.code_in[4] ^ bus.code_in[5] ^ bus.code_in[6] ^ bus.code_in[7];
    end

    always_comb begin
        fixed = s1_code;
        for (int i = 1; i <= 7; i++) begin
            if (s1_syn == 3'(i)) fixed[i] = ~s1_code[i];
        end
        fix_msg = {fixed[3], fixed[5], fixed[6], fixed[7]};
    end

    // code_in is only captured on a handshake, so idle-bus X never reaches the pipe
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_code  <= '0;
            s1_syn   <= '0;
        end else if (take) begin
            s1_valid <= 1'b1;
            s1_code  <= bus.code_in;
            s1_syn   <= syn;
        end else if (adv2) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.msg_out   <= '0;
            bus.err_pos   <= '0;
            bus.corrected <= 1'b0;
        end else if (adv2) begin
            bus.out_valid <= s1_valid;
            if (s1_valid) begin
                bus.msg_out   <= fix_msg;
                bus.err_pos   <= s1_syn;
                bus.corrected <= (s1_syn != 3'd0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            corr_count <= '0;
        end else if (out_hs && bus.corrected && (corr_count != {CNT_W{1'b1}})) begin
            corr_count <= corr_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hamming_decoder_pipe.sv
// Directed bench for hamming_decoder_pipe: clean/data/parity errors, full sweep,
// backpressure ordering, counter saturation and clear, reset mid-stream.
module tb_hamming_decoder_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr_cnt, clr_cnt2;
    logic [15:0] corr_count;
    logic [1:0]  corr_count2;
    int          total = 0;
    int          bad = 0;
    int          exp_cnt = 0;

    hamming_decoder_pipe_if b1();
    hamming_decoder_pipe_if b2();

    hamming_decoder_pipe #(.CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .bus(b1), .clr_cnt(clr_cnt), .corr_count(corr_count)
    );

    hamming_decoder_pipe #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .bus(b2), .clr_cnt(clr_cnt2), .corr_count(corr_count2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:7] c);
        b1.in_valid = 1'b1;
        b1.code_in  = c;
        tick();
        b1.in_valid = 1'b0;
        b1.code_in  = 'x;
    endtask

    // independent encoder: {p1,p2,d1,p3,d2,d3,d4}
    function automatic logic [1:7] enc(input logic [3:0] m);
        logic d1, d2, d3, d4;
        {d1, d2, d3, d4} = m;
        return {d1 ^ d2 ^ d4, d1 ^ d3 ^ d4, d1, d2 ^ d3 ^ d4, d2, d3, d4};
    endfunction

    logic [1:7] bp_code [4];
    logic [3:0] bp_msg  [4];
    logic [2:0] bp_err  [4];

    initial begin
        logic [6:0] q[$];
        logic [6:0] ent;
        logic [1:7] cw;
        logic [3:0] m;
        int         e, nin, nout;
        logic       acc;

        bp_code[0] = 7'b0110011; bp_msg[0] = 4'b1011; bp_err[0] = 3'd0;
        bp_code[1] = 7'b0110111; bp_msg[1] = 4'b1011; bp_err[1] = 3'd5;
        bp_code[2] = 7'b1000000; bp_msg[2] = 4'b0000; bp_err[2] = 3'd1;
        bp_code[3] = 7'b1111111; bp_msg[3] = 4'b1111; bp_err[3] = 3'd0;

        rst = 1'b1; clr_cnt = 1'b0; clr_cnt2 = 1'b0;
        b1.in_valid = 1'b0; b1.code_in = 'x; b1.out_ready = 1'b1;
        b2.in_valid = 1'b0; b2.code_in = 'x; b2.out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", b1.out_valid, 0);
        chk("rst_in_ready", b1.in_ready, 1);
        chk("rst_msg", b1.msg_out, 0);
        chk("rst_err", b1.err_pos, 0);
        chk("rst_corr", b1.corrected, 0);
        chk("rst_cnt", corr_count, 0);

        // clean word, latency 2
        send(7'b0110011);
        chk("t1_lat_n1", b1.out_valid, 0);
        tick();
        chk("t1_valid", b1.out_valid, 1);
        chk("t1_msg", b1.msg_out, 4'b1011);
        chk("t1_err", b1.err_pos, 0);
        chk("t1_corr", b1.corrected, 0);
        tick();
        chk("t1_cnt", corr_count, 0);

        // data-bit error
        send(7'b0110111);
        tick();
        chk("t2_msg", b1.msg_out, 4'b1011);
        chk("t2_err", b1.err_pos, 5);
        chk("t2_corr", b1.corrected, 1);
        tick();
        exp_cnt = 1;
        chk("t2_cnt", corr_count, 1);

        // parity-bit error
        send(7'b1000000);
        tick();
        chk("t3_msg", b1.msg_out, 4'b0000);
        chk("t3_err", b1.err_pos, 1);
        chk("t3_corr", b1.corrected, 1);
        tick();
        exp_cnt = 2;

        // sweep 16 messages x {no error, bit 1..7}, back-to-back
        for (int k = 0; k < 128 + 6; k++) begin
            if (b1.out_valid) begin
                if (q.size() == 0) begin
                    chk("sweep_extra", 1, 0);
                end else begin
                    ent = q.pop_front();
                    chk("sweep_msg", b1.msg_out, ent[6:3]);
                    chk("sweep_err", b1.err_pos, ent[2:0]);
                    chk("sweep_corr", b1.corrected, ent[2:0] != 3'd0);
                    if (ent[2:0] != 3'd0) exp_cnt++;
                end
            end
            if (k < 128) begin
                m  = 4'(k >> 3);
                e  = k & 7;
                cw = enc(m);
                if (e != 0) cw[e] = ~cw[e];
                q.push_back({m, 3'(e)});
                b1.in_valid = 1'b1;
                b1.code_in  = cw;
            end else begin
                b1.in_valid = 1'b0;
                b1.code_in  = 'x;
            end
            tick();
        end
        chk("sweep_left", q.size(), 0);
        chk("sweep_cnt", corr_count, exp_cnt);

        // clear coincident with a corrected output handshake
        send(7'b0110111);
        tick();
        chk("clr_pre_valid", b1.out_valid, 1);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        exp_cnt = 0;
        chk("clr_cnt", corr_count, 0);

        // backpressure: out_ready low for cycles 0..4
        nin = 0; nout = 0;
        for (int cyc = 0; cyc < 20 && nout < 4; cyc++) begin
            b1.out_ready = (cyc >= 5);
            #1;
            if (b1.out_valid) begin
                chk("bp_msg", b1.msg_out, bp_msg[nout]);
                chk("bp_err", b1.err_pos, bp_err[nout]);
                if (b1.out_ready) begin
                    if (bp_err[nout] != 3'd0) exp_cnt++;
                    nout++;
                end
            end
            if (cyc == 2 || cyc == 4) chk("bp_in_ready_low", b1.in_ready, 0);
            if (cyc == 4) chk("bp_accepted", nin, 2);
            if (nin < 4) begin
                b1.in_valid = 1'b1;
                b1.code_in  = bp_code[nin];
            end else begin
                b1.in_valid = 1'b0;
                b1.code_in  = 'x;
            end
            #1;
            acc = b1.in_valid && b1.in_ready;
            tick();
            if (acc) nin++;
        end
        b1.in_valid = 1'b0;
        b1.code_in  = 'x;
        chk("bp_nout", nout, 4);
        chk("bp_no_dup", b1.out_valid, 0);
        chk("bp_cnt", corr_count, exp_cnt);

        // CNT_W=2 saturation: 5 corrected words
        for (int k = 0; k < 5; k++) begin
            b2.in_valid = 1'b1;
            b2.code_in  = 7'b0110111;
            tick();
        end
        b2.in_valid = 1'b0;
        b2.code_in  = 'x;
        for (int k = 0; k < 4; k++) tick();
        chk("sat_cnt", corr_count2, 3);

        // reset with both stages full
        b1.out_ready = 1'b0;
        b1.in_valid  = 1'b1;
        b1.code_in   = 7'b0110111;
        tick();
        b1.code_in   = 7'b1000000;
        tick();
        b1.in_valid  = 1'b0;
        b1.code_in   = 'x;
        chk("mrst_full", b1.in_ready, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mrst_out_valid", b1.out_valid, 0);
        chk("mrst_in_ready", b1.in_ready, 1);
        chk("mrst_cnt", corr_count, 0);
        b1.out_ready = 1'b1;
        tick();
        chk("mrst_no_out", b1.out_valid, 0);
        send(7'b0110111);
        tick();
        chk("mrst_valid", b1.out_valid, 1);
        chk("mrst_msg", b1.msg_out, 4'b1011);
        chk("mrst_err", b1.err_pos, 5);
        tick();
        chk("mrst_cnt_after", corr_count, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
